ksa_swap_fsm: RTL and testbench
===============================

// Module: ksa_swap_fsm
// PURPOSE
//  Second RC4 key-scheduling phase: after S-memory holds the identity permutation S[i]=i,
//  runs j=j+S[i]+key[i mod KEY_BYTES]; swap(S[i],S[j]) for i=0..255.
//  Sits directly downstream of init_ram_fsm: its fin_strobe drives start here.
//  Owns the single-port 256x8 s_memory port while busy; top-level muxes the port.
// PARAMETERS
//  KEY_BYTES   3   secret key length in bytes; key byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8].
// PORTS
//  clk         in   1              system clock, all logic on rising edge
//  rst         in   1              asynchronous, active-low reset
//  start       in   1              1-cycle strobe; accepted only in IDLE
//  secret_key  in   8*KEY_BYTES    key, byte 0 in MSBs; must be stable while busy
//  rddata      in   8              s_memory q; valid the cycle after addr is presented
//  addr        out  8              s_memory address
//  wrdata      out  8              s_memory write data
//  wren        out  1              s_memory write enable
//  busy        out  1              high from first READ_I through DONE inclusive
//  fin_strobe  out  1              1-cycle pulse when the 256th iteration completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, i=0, j=0, kidx=0, si=sj=0; addr=0, wrdata=0, wren=0,
//   busy=0, fin_strobe=0. All outputs registered or decoded from registered state only.
//  Registers: i[7:0], j[7:0], kidx (0..KEY_BYTES-1 counter, no divider), si[7:0], sj[7:0].
//  States / per-cycle actions (wren=0 unless stated):
//   IDLE   : busy=0. start=1 -> i=0, j=0, kidx=0, go READ_I. start ignored in all other states.
//   READ_I : addr=i -> LATCH_I.
//   LATCH_I: si<=rddata; j<=j+rddata+key[kidx] (8-bit, mod 256 wrap) -> READ_J.
//   READ_J : addr=j -> LATCH_J.
//   LATCH_J: sj<=rddata -> WRITE_I.
//   WRITE_I: addr=i, wrdata=sj, wren=1 -> WRITE_J.
//   WRITE_J: addr=j, wrdata=si, wren=1; if i==255 -> DONE, else i<=i+1,
//            kidx<=(kidx==KEY_BYTES-1)?0:kidx+1 -> READ_I.
//   DONE   : fin_strobe=1 for exactly this cycle -> IDLE.
//  Latency: 6 cycles/iteration; start-accept edge to fin_strobe = 1 + 256*6 = 1537 cycles.
//  i==j: WRITE_I then WRITE_J write the same value to the same address; final S correct.
//  j wraps modulo 256 with no carry out; i wrap never occurs (terminates at 255).
//  Reset mid-operation: FSM returns to IDLE immediately, wren drops asynchronously;
//   s_memory left partially permuted -- upstream init must be rerun before a new start.
//  start held high across DONE->IDLE re-triggers a run; upstream must pulse.
// CONFIGURATION
//  KSA_SAME_IDX_SKIP_EN defined: in LATCH_I, if computed j_next==i, skip READ_J..WRITE_J:
//   register j, advance i/kidx (or go DONE if i==255) directly -> that iteration takes 2 cycles,
//   no write issued. Memory contents identical to the non-skip build.
//  Not defined: every iteration takes exactly 6 cycles and always issues both writes.
// TESTING (bench models s_memory with 1-cycle read latency, preloaded S[i]=i; golden C/SV model)
//  1. key=24'h000000, start pulse -> iterations i=0,1 are self-swaps; i=2: j=3, writes
//     addr2<=8'h03 then addr3<=8'h02; final S matches golden model byte-for-byte.
//  2. key=24'h000102 -> i=1: j=0+1+1=2, writes addr1<=8'h02, addr2<=8'h01; full S matches model.
//  3. Any key, macro off -> fin_strobe exactly 1537 cycles after start-accept edge, high 1 cycle;
//     busy high for 1537 cycles, then 0; wren never high outside WRITE_I/WRITE_J.
//  4. key=24'h4A3B2C, extra start pulses at cycles 10 and 800 -> ignored; single fin_strobe,
//     S matches model.
//  5. Assert rst=0 at cycle 500 -> same cycle wren=0, busy=0, fin_strobe=0; reload identity,
//     start again -> correct S and 1537-cycle latency.
//  6. KSA_SAME_IDX_SKIP_EN, key=24'h000000 -> i=0 and i=1 take 2 cycles each, no wren;
//     total latency = 1537 - 4*(self-swap count from model); S identical to test 1.

Source files
------------

// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key-scheduling swap phase driving a 256x8 single-port S-memory
// Optional build macro KSA_SAME_IDX_SKIP_EN: self-swap iterations skip the j read and both writes.
module ksa_swap_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             rddata,
  output logic [7:0]             addr,
  output logic [7:0]             wrdata,
  output logic                   wren,
  output logic                   busy,
  output logic                   fin_strobe
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_I,
    S_LATCH_I,
    S_READ_J,
    S_LATCH_J,
    S_WRITE_I,
    S_WRITE_J,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [KW-1:0] kidx_q, kidx_d;
  logic [7:0]    si_q, si_d;
  logic [7:0]    sj_q, sj_d;

  logic [7:0]    key_byte;
  logic [7:0]    j_next;
  logic [KW-1:0] kidx_inc;

  // Key byte 0 sits in the MSBs; kidx walks the key without a modulo divider.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KW'(k)) key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
    end
  end

  assign j_next   = j_q + rddata + key_byte;
  assign kidx_inc = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    kidx_d     = kidx_q;
    si_d       = si_q;
    sj_d       = sj_q;
    addr       = '0;
    wrdata     = '0;
    wren       = 1'b0;
    busy       = (state_q != S_IDLE);
    fin_strobe = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = S_READ_I;
        end
      end
      S_READ_I: begin
        addr    = i_q;
        state_d = S_LATCH_I;
      end
      S_LATCH_I: begin
        si_d    = rddata;
        j_d     = j_next;
        state_d = S_READ_J;
`ifdef KSA_SAME_IDX_SKIP_EN
        // Swapping S[i] with itself leaves memory unchanged, so skip straight on.
        if (j_next == i_q) begin
          if (i_q == 8'd255) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 8'd1;
            kidx_d  = kidx_inc;
            state_d = S_READ_I;
          end
        end
`endif
      end
      S_READ_J: begin
        addr    = j_q;
        state_d = S_LATCH_J;
      end
      S_LATCH_J: begin
        sj_d    = rddata;
        state_d = S_WRITE_I;
      end
      S_WRITE_I: begin
        addr    = i_q;
        wrdata  = sj_q;
        wren    = 1'b1;
        state_d = S_WRITE_J;
      end
      S_WRITE_J: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
        if (i_q == 8'd255) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = kidx_inc;
          state_d = S_READ_I;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb/tb_ksa_swap_fsm.sv - directed self-checking bench for ksa_swap_fsm against a golden RC4 KSA model
module tb_ksa_swap_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  rddata;
  logic [7:0]  addr;
  logic [7:0]  wrdata;
  logic        wren;
  logic        busy;
  logic        fin_strobe;

  ksa_swap_fsm #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret_key (secret_key),
    .rddata     (rddata),
    .addr       (addr),
    .wrdata     (wrdata),
    .wren       (wren),
    .busy       (busy),
    .fin_strobe (fin_strobe)
  );

  always #5 clk = ~clk;

  // S-memory model: 1-cycle read latency, identity preload on load_id.
  logic [7:0] mem [256];
  logic       load_id = 1'b0;

  always @(posedge clk) begin
    if (load_id) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] gold [256];
  int         self_cnt;

  function automatic void golden(input logic [23:0] key);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
    j = 8'd0;
    self_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + gold[i] + kb;
      if (j == 8'(i)) self_cnt++;
      t       = gold[i];
      gold[i] = gold[j];
      gold[j] = t;
    end
  endfunction

  int         lat, fin_cnt, busy_cnt, wr_cnt, wr_bad;
  logic [7:0] wr_a [8];
  logic [7:0] wr_d [8];

  task automatic run(input logic [23:0] key, input int pa, input int pb, input int abort_at);
    secret_key = key;
    @(negedge clk) load_id = 1'b1;
    @(negedge clk) load_id = 1'b0;
    lat = 0; fin_cnt = 0; busy_cnt = 0; wr_cnt = 0; wr_bad = 0;
    start = 1'b1;
    @(negedge clk);
    // Cycle k=1 is the first cycle after the start-accept edge.
    for (int k = 1; k <= 3000; k++) begin
      start = (k == pa) || (k == pb);
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_wren", wren, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_fin", fin_strobe, 1'b0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        return;
      end
      busy_cnt += int'(busy);
      if (fin_strobe) begin
        fin_cnt++;
        if (lat == 0) lat = k;
      end
      if (wren) begin
        if (!busy) wr_bad++;
        if (wr_cnt < 8) begin
          wr_a[wr_cnt] = addr;
          wr_d[wr_cnt] = wrdata;
        end
        wr_cnt++;
      end
      if (lat != 0 && k >= lat + 5) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int exp_lat, exp_wr, bad;
`ifdef KSA_SAME_IDX_SKIP_EN
    exp_lat = 1537 - 4 * self_cnt;
    exp_wr  = 512 - 2 * self_cnt;
`else
    exp_lat = 1537;
    exp_wr  = 512;
`endif
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_fin_count"}, fin_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, "_writes"}, wr_cnt, exp_wr);
    chk({tag, "_wren_idle"}, wr_bad, 0);
    chk({tag, "_s_bad_bytes"}, bad, 0);
  endtask

  int off;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 8'h00);
    chk("rst_wrdata", wrdata, 8'h00);
    chk("rst_wren", wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fin", fin_strobe, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // key 0: i=0,1 self-swap, i=2 swaps with j=3
    golden(24'h000000);
    run(24'h000000, 0, 0, 0);
    check_run("k0");
`ifdef KSA_SAME_IDX_SKIP_EN
    off = 0;
`else
    off = 4;
`endif
    chk("k0_w_i2_addr", wr_a[off], 8'h02);
    chk("k0_w_i2_data", wr_d[off], 8'h03);
    chk("k0_w_j3_addr", wr_a[off+1], 8'h03);
    chk("k0_w_j3_data", wr_d[off+1], 8'h02);

    // key 000102: i=1 swaps with j=2
    golden(24'h000102);
    run(24'h000102, 0, 0, 0);
    check_run("k102");
`ifdef KSA_SAME_IDX_SKIP_EN
    off = 0;
`else
    off = 2;
`endif
    chk("k102_w_i1_addr", wr_a[off], 8'h01);
    chk("k102_w_i1_data", wr_d[off], 8'h02);
    chk("k102_w_j2_addr", wr_a[off+1], 8'h02);
    chk("k102_w_j2_data", wr_d[off+1], 8'h01);

    // start pulses while busy must be ignored
    golden(24'h4A3B2C);
    run(24'h4A3B2C, 10, 800, 0);
    check_run("k4a");

    // reset mid-run, then a clean rerun from identity
    run(24'h123456, 0, 0, 500);
    chk("post_abort_busy", busy, 1'b0);
    chk("post_abort_addr", addr, 8'h00);
    golden(24'h123456);
    run(24'h123456, 0, 0, 0);
    check_run("rerun");

    golden(24'hFFFFFF);
    run(24'hFFFFFF, 0, 0, 0);
    check_run("kff");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
